// File: rtl/score_counter_pkg.sv
// Shared game types: BCD digit and two-digit score, plus small helpers
// reused by the score counter, the score display and game control.
package score_counter_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } score_bcd_t;

    // Binary value of a two-digit BCD score, 0..99.
    function automatic logic [6:0] bcd_to_bin(input score_bcd_t s);
        return 7'(s.tens) * 7'd10 + 7'(s.ones);
    endfunction

    function automatic bcd_digit_t clamp_digit(input logic [DIGIT_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/score_counter_bcd_digit_add.sv
// Combinational single-digit BCD adder; inputs are assumed to be valid BCD.
module bcd_digit_add
    import score_counter_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [DIGIT_W:0] raw;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        sum  = raw[DIGIT_W-1:0];
        cout = 1'b0;
        if (raw >= 5'd10) begin
            sum  = DIGIT_W'(raw - 5'd10);
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/score_counter.sv
// Two-digit BCD score accumulator with frame-synchronous display shadow,
// sticky win flag and frame-rate blink enable.
module score_counter
    import score_counter_pkg::*;
#(
    parameter int WIN_SCORE    = 10,
    parameter int SATURATE     = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               add_valid,
    input  logic [DIGIT_W-1:0] add_amount,
    output logic               add_ready,
    input  logic               frame_start,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               win,
    output logic               blink
);

    localparam int              CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]       WIN_BIN  = 7'(WIN_SCORE);

    score_bcd_t       work_q, work_d;
    score_bcd_t       disp_q, disp_d;
    logic             win_q, win_d;
    logic             blink_q, blink_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    bcd_digit_t amt;
    bcd_digit_t sum_o, sum_t;
    logic       carry_o, carry_t;
    logic       accept;
    score_bcd_t add_res;

    assign amt       = clamp_digit(add_amount);
    assign add_ready = !win_q;
    assign accept    = add_valid && add_ready;

    bcd_digit_add u_add_ones (
        .a    (work_q.ones),
        .b    (amt),
        .cin  (1'b0),
        .sum  (sum_o),
        .cout (carry_o)
    );

    bcd_digit_add u_add_tens (
        .a    (work_q.tens),
        .b    (4'd0),
        .cin  (carry_o),
        .sum  (sum_t),
        .cout (carry_t)
    );

    // On tens overflow the adder already yields tens=0, which is the modulo-100 result.
    always_comb begin
        add_res = '{tens: sum_t, ones: sum_o};
        if (carry_t && (SATURATE != 0)) begin
            add_res = '{tens: BCD_MAX, ones: BCD_MAX};
        end
    end

    always_comb begin
        work_d  = work_q;
        disp_d  = disp_q;
        win_d   = win_q;
        blink_d = blink_q;
        cnt_d   = cnt_q;
        if (clear) begin
            work_d  = '0;
            disp_d  = '0;
            win_d   = 1'b0;
            blink_d = 1'b1;
            cnt_d   = '0;
        end else begin
            if (accept) begin
                work_d = add_res;
            end
            // Display samples the pre-edge score, so a same-edge add waits a frame.
            if (frame_start) begin
                disp_d = work_q;
            end
            if (bcd_to_bin(work_q) >= WIN_BIN) begin
                win_d = 1'b1;
            end
            if (!win_q) begin
                blink_d = 1'b1;
                cnt_d   = '0;
            end else if (frame_start) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    blink_d = !blink_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q  <= '0;
            disp_q  <= '0;
            win_q   <= 1'b0;
            blink_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            work_q  <= work_d;
            disp_q  <= disp_d;
            win_q   <= win_d;
            blink_q <= blink_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tens  = disp_q.tens;
    assign ones  = disp_q.ones;
    assign win   = win_q;
    assign blink = blink_q;

endmodule

// File: tb/tb_score_counter.sv
// Three score_counter configurations driven with shared stimulus; an integer
// reference model fills a scoreboard each cycle and directed checks pin key values.
module tb_score_counter;

    logic       clk = 1'b0;
    logic       rst, clear, add_valid, frame_start;
    logic [3:0] add_amount;

    logic [3:0] tens0, ones0, tens1, ones1, tens2, ones2;
    logic       win0, blink0, rdy0, win1, blink1, rdy1, win2, blink2, rdy2;

    always #5 clk = ~clk;

    score_counter #(.WIN_SCORE(10), .SATURATE(1), .BLINK_FRAMES(30)) u_dut0 (
        .clk(clk), .rst(rst), .clear(clear), .add_valid(add_valid), .add_amount(add_amount),
        .add_ready(rdy0), .frame_start(frame_start), .tens(tens0), .ones(ones0),
        .win(win0), .blink(blink0)
    );

    score_counter #(.WIN_SCORE(99), .SATURATE(1), .BLINK_FRAMES(2)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear), .add_valid(add_valid), .add_amount(add_amount),
        .add_ready(rdy1), .frame_start(frame_start), .tens(tens1), .ones(ones1),
        .win(win1), .blink(blink1)
    );

    score_counter #(.WIN_SCORE(99), .SATURATE(0), .BLINK_FRAMES(2)) u_dut2 (
        .clk(clk), .rst(rst), .clear(clear), .add_valid(add_valid), .add_amount(add_amount),
        .add_ready(rdy2), .frame_start(frame_start), .tens(tens2), .ones(ones2),
        .win(win2), .blink(blink2)
    );

    typedef struct {
        int work;
        int disp;
        int cnt;
        bit win;
        bit blink;
    } mstate_t;

    typedef struct {
        int tens;
        int ones;
        int win;
        int blink;
        int ready;
    } exp_t;

    int      win_p [3] = '{10, 99, 99};
    int      sat_p [3] = '{1, 1, 0};
    int      bf_p  [3] = '{30, 2, 2};
    mstate_t m     [3];
    exp_t    sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input int i);
        mstate_t s, n;
        int      a, v;
        s = m[i];
        n = m[i];
        if (rst || clear) begin
            n.work = 0; n.disp = 0; n.win = 0; n.blink = 1; n.cnt = 0;
        end else begin
            if (add_valid && !s.win) begin
                a = (add_amount > 9) ? 9 : int'(add_amount);
                v = s.work + a;
                if (v > 99) v = (sat_p[i] != 0) ? 99 : v - 100;
                n.work = v;
            end
            if (frame_start) n.disp = s.work;
            if (s.work >= win_p[i]) n.win = 1;
            if (!s.win) begin
                n.blink = 1;
                n.cnt   = 0;
            end else if (frame_start) begin
                if (s.cnt == bf_p[i] - 1) begin
                    n.cnt   = 0;
                    n.blink = !s.blink;
                end else begin
                    n.cnt = s.cnt + 1;
                end
            end
        end
        m[i] = n;
    endtask

    task automatic get_obs(input int i, output exp_t o);
        case (i)
            0:       o = '{int'(tens0), int'(ones0), int'(win0), int'(blink0), int'(rdy0)};
            1:       o = '{int'(tens1), int'(ones1), int'(win1), int'(blink1), int'(rdy1)};
            default: o = '{int'(tens2), int'(ones2), int'(win2), int'(blink2), int'(rdy2)};
        endcase
    endtask

    // One clock: drive inputs, let the model predict, then compare #1 after the edge.
    task automatic cycle(input bit r, input bit c, input bit v, input int a, input bit f);
        exp_t e, o;
        rst         = r;
        clear       = c;
        add_valid   = v;
        add_amount  = 4'(a);
        frame_start = f;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            model_step(i);
            sb.push_back('{m[i].disp / 10, m[i].disp % 10, int'(m[i].win), int'(m[i].blink),
                           int'(!m[i].win)});
        end
        #1;
        rst = 0; clear = 0; add_valid = 0; add_amount = '0; frame_start = 0;
        for (int i = 0; i < 3; i++) begin
            if (sb.size() == 0) begin
                check($sformatf("d%0d.sb_empty", i), 1, 0);
            end else begin
                e = sb.pop_front();
                get_obs(i, o);
                check($sformatf("d%0d.tens", i),  o.tens,  e.tens);
                check($sformatf("d%0d.ones", i),  o.ones,  e.ones);
                check($sformatf("d%0d.win", i),   o.win,   e.win);
                check($sformatf("d%0d.blink", i), o.blink, e.blink);
                check($sformatf("d%0d.ready", i), o.ready, e.ready);
            end
        end
    endtask

    task automatic add(input int a);
        cycle(0, 0, 1, a, 0);
    endtask

    task automatic frame();
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic do_clear();
        cycle(0, 1, 0, 0, 0);
    endtask

    initial begin
        rst = 1; clear = 0; add_valid = 0; add_amount = '0; frame_start = 0;

        // Reset state
        cycle(1, 0, 0, 0, 0);
        frame();
        check("rst.tens", int'(tens0), 0);
        check("rst.ones", int'(ones0), 0);
        check("rst.win", int'(win0), 0);
        check("rst.blink", int'(blink0), 1);
        check("rst.ready", int'(rdy0), 1);

        // Carry across digits, display only updates on frame_start
        add(7);
        add(5);
        check("carry.hold_t", int'(tens0), 0);
        check("carry.hold_o", int'(ones0), 0);
        frame();
        check("carry.disp_t", int'(tens0), 1);
        check("carry.disp_o", int'(ones0), 2);

        // Add on the same edge as frame_start is shown one frame later
        do_clear();
        add(3);
        cycle(0, 0, 1, 4, 1);
        check("coinc.disp_o", int'(ones0), 3);
        frame();
        check("coinc.next_o", int'(ones0), 7);

        // WIN_SCORE=10 threshold and ignored adds afterwards
        do_clear();
        add(9);
        add(1);
        check("win.not_yet", int'(win0), 0);
        idle();
        check("win.set", int'(win0), 1);
        check("win.ready", int'(rdy0), 0);
        add(5);
        frame();
        check("win.disp_t", int'(tens0), 1);
        check("win.disp_o", int'(ones0), 0);

        // Saturate vs wrap at 95 + 9, blink period of two frames
        do_clear();
        for (int k = 0; k < 10; k++) add(9);
        add(5);
        add(9);
        idle();
        check("sat.win", int'(win1), 1);
        check("wrap.win", int'(win2), 0);
        frame();
        check("sat.disp_t", int'(tens1), 9);
        check("sat.disp_o", int'(ones1), 9);
        check("wrap.disp_t", int'(tens2), 0);
        check("wrap.disp_o", int'(ones2), 4);
        check("sat.blink1", int'(blink1), 1);
        frame();
        check("sat.blink2", int'(blink1), 0);
        frame();
        frame();
        check("sat.blink4", int'(blink1), 1);
        check("wrap.blink", int'(blink2), 1);

        // Clear wins over a simultaneous add and frame_start
        do_clear();
        for (int k = 0; k < 4; k++) add(9);
        add(6);
        frame();
        check("clr.pre_t", int'(tens1), 4);
        check("clr.pre_o", int'(ones1), 2);
        check("clr.pre_win", int'(win0), 1);
        cycle(0, 1, 1, 3, 1);
        check("clr.tens", int'(tens1), 0);
        check("clr.ones", int'(ones1), 0);
        check("clr.win", int'(win0), 0);
        check("clr.blink", int'(blink0), 1);
        frame();
        check("clr.no_add", int'(ones1), 0);
        add(12);
        frame();
        check("clamp.tens", int'(tens1), 0);
        check("clamp.ones", int'(ones1), 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
